sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
Serial-in parallel-out stage that sits directly downstream of the team's parallel-in serial-out shift register. It reassembles LSB-first serial bits into DATA_WIDTH-bit words, using a start strobe for framing. Completed words are presented on a valid/ready output port backed by a single holding register. The block reports framing errors and overflow.

Parameters:
DATA_WIDTH, 16, word width and number of serial bits per word (>=2)
AUTO_REARM, 0, 1 = after a word completes, the next valid bit starts a new word without needing sin_start; 0 = return to IDLE and wait for sin_start

Ports:
clk  input  1  clock; all logic on rising edge
resetn  input  1  synchronous, active-low reset
sin  input  1  serial data bit, LSB of word first (connects to upstream dout)
sin_valid  input  1  qualifies sin this cycle; no bit is consumed when low
sin_start  input  1  marks sin as bit 0 of a new word; ignored unless sin_valid
dout  output  DATA_WIDTH  assembled word; bit k = k-th bit received
dout_valid  output  1  dout holds an undelivered word
dout_ready  input  1  consumer accepts dout when dout_valid & dout_ready
frame_err  output  1  one-cycle pulse: partial word discarded by a premature sin_start
overflow  output  1  sticky: a completed word was dropped because the slot was full
ovf_clr  input  1  clears overflow (set takes priority in the same cycle)

Behaviour:
- Reset (resetn=0 at posedge) puts every output and register to 0: state=IDLE, bit counter cnt=0, shift register=0, dout=0, dout_valid=0, frame_err=0, overflow=0. A reset mid-word discards the partial word and any held output word.
- Storage: shift register sr[DATA_WIDTH-1:0]. On each accepted bit, sr <= {sin, sr[DATA_WIDTH-1:1]}. After DATA_WIDTH accepted bits, sr[k] = k-th bit received. cnt width is $clog2(DATA_WIDTH+1).
- FSM states: IDLE and SHIFT.
  - IDLE with sin_valid & sin_start: accept bit, cnt<=1, go to SHIFT.
  - IDLE with sin_valid & ~sin_start: bit dropped silently, stay in IDLE. Exception: when AUTO_REARM=1 and at least one word has completed since reset, treat the bit as bit 0 (cnt<=1, go to SHIFT).
  - SHIFT with sin_valid & ~sin_start: accept bit, cnt<=cnt+1.
  - SHIFT with sin_valid & sin_start (at any cnt, including the bit that would be last): discard the partial word, frame_err=1 on the next cycle, and accept the bit as bit 0 (cnt<=1).
  - Any state with ~sin_valid: hold all state. Gaps between bits of any length are allowed.
- Completion: the accepted bit with cnt==DATA_WIDTH-1 completes the word. Then cnt<=0 and state goes to IDLE; with AUTO_REARM=1 the state stays in SHIFT with cnt=0 instead.
- Completion latency: the word is written to dout, with dout_valid=1, at the same edge that samples the last bit. It is therefore visible in the following cycle.
- Output slot:
  - dout_valid clears on dout_valid & dout_ready unless a completion happens in the same cycle.
  - Completion with the slot empty, or with the slot full and dout_ready=1: load dout, dout_valid=1. This allows back-to-back words with no bubble.
  - Completion with the slot full and dout_ready=0: the new word is dropped, dout and dout_valid are unchanged, overflow<=1.
  - dout is stable while dout_valid & ~dout_ready.
- overflow stays set until ovf_clr=1 with no new drop in the same cycle.
- frame_err is a registered pulse exactly one cycle wide per restart event.
- With AUTO_REARM=1, "at least one word completed since reset" is tracked by a 1-bit armed flag. That flag is cleared by reset only.

Test Plan:
- Word 0xA5C3 sent LSB first over 16 consecutive valid cycles, sin_start on bit 0, dout_ready=1 -> dout=0xA5C3 and dout_valid=1 for exactly one cycle, starting the cycle after bit 15; frame_err=0, overflow=0.
- Same word 0xA5C3 with sin_valid low for 3 cycles after bits 4 and 11 -> dout=0xA5C3; completion delayed by exactly 6 cycles.
- Word 0x1234 completes with dout_ready=0, then word 0xFFFF completes -> dout stays 0x1234, overflow=1. Raise dout_ready -> 0x1234 is delivered once. ovf_clr -> overflow=0.
- sin_start reasserted at bit 9 of a word, followed by a full 0x00FF word -> frame_err pulses once, output is 0x00FF only.
- resetn low for 1 cycle at bit 7 of a word, then 0xBEEF sent with start -> all outputs 0 after reset, next output is 0xBEEF.
- AUTO_REARM=1: 0x0001 then 0x8000 sent back-to-back with sin_start only on the first bit, dout_ready=1 -> two consecutive valid cycles, 0x0001 then 0x8000, no bubble.

Source files
------------

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: reassembles LSB-first serial bits into words behind a single-entry valid/ready slot
module sipo_deserializer #(
  parameter int DATA_WIDTH = 16,
  parameter bit AUTO_REARM = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sin,
  input  logic                  sin_valid,
  input  logic                  sin_start,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  ovf_clr
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_base;
  logic [DATA_WIDTH-1:0] sr, sr_n, dout_n;
  logic armed, armed_n, dv_n, fe_n, ovf_n;
  logic accept, restart, complete, load, drop;
  // state and output registers; a restart with no bits collected is not a framing error
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sr         <= sr_n;
      dout       <= dout_n;
      dout_valid <= dv_n;
      frame_err  <= fe_n;
      overflow   <= ovf_n;
      armed      <= armed_n;
    end
  end
  // bit acceptance, word completion and output slot next-state
  always_comb begin
    accept   = sin_valid & (state == SHIFT | sin_start | (AUTO_REARM & armed));
    restart  = sin_valid & sin_start & (state == SHIFT) & (cnt != '0);
    cnt_base = sin_start ? '0 : cnt;
    complete = accept & (cnt_base == CW'(DATA_WIDTH - 1));
    load     = complete & (~dout_valid | dout_ready);
    drop     = complete & dout_valid & ~dout_ready;
    sr_n     = accept ? {sin, sr[DATA_WIDTH-1:1]} : sr;
    cnt_n    = complete ? '0 : accept ? cnt_base + 1'b1 : cnt;
    state_n  = complete ? (AUTO_REARM ? SHIFT : IDLE) : accept ? SHIFT : state;
    dout_n   = load ? sr_n : dout;
    dv_n     = load | (dout_valid & ~dout_ready);
    fe_n     = restart;
    ovf_n    = drop | (overflow & ~ovf_clr);
    armed_n  = armed | (AUTO_REARM & complete);
  end
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed checks of framing, latency, overflow, restart, reset and auto-rearm
module tb_sipo_deserializer;
  logic clk = 1'b0, resetn = 1'b0, sin = 1'b0, sin_valid = 1'b0, sin_start = 1'b0;
  logic dout_ready = 1'b1, ovf_clr = 1'b0;
  logic [15:0] dout, dout_a;
  logic dout_valid, frame_err, overflow, dout_valid_a, frame_err_a, overflow_a;
  int passed = 0, total = 0, cyc = 0;
  int fe_cnt = 0, dlv_cnt = 0, dlv_a = 0, fe0, d0, a0;
  logic [15:0] last_dout = '0, last_a = '0;
  sipo_deserializer #(.DATA_WIDTH(16), .AUTO_REARM(1'b0)) dut (
    .clk(clk), .resetn(resetn), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .frame_err(frame_err), .overflow(overflow), .ovf_clr(ovf_clr));
  sipo_deserializer #(.DATA_WIDTH(16), .AUTO_REARM(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
    .dout(dout_a), .dout_valid(dout_valid_a), .dout_ready(dout_ready),
    .frame_err(frame_err_a), .overflow(overflow_a), .ovf_clr(ovf_clr));
  always #5 clk = ~clk;
  // count frame_err cycles and deliveries mid-cycle
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (dout_valid && dout_ready) begin dlv_cnt++; last_dout = dout; end
    if (dout_valid_a && dout_ready) begin dlv_a++; last_a = dout_a; end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask
  task automatic send(input logic [15:0] w, input int n, input bit st, input int gap);
    cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && (i == 5 || i == 12)) begin
        sin_valid = 1'b0;
        sin_start = 1'b0;
        repeat (gap) begin tick(); cyc++; end
      end
      sin = w[i];
      sin_valid = 1'b1;
      sin_start = st && i == 0;
      tick();
      cyc++;
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_fe", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_valid_a", dout_valid_a, 0);
    resetn = 1'b1;
    tick();
    send(16'hA5C3, 16, 1'b1, 0);
    chk("t1_cyc", cyc, 16);
    chk("t1_dout", dout, 16'hA5C3);
    chk("t1_valid", dout_valid, 1);
    chk("t1_fe", frame_err, 0);
    chk("t1_ovf", overflow, 0);
    tick();
    chk("t1_onecycle", dout_valid, 0);
    send(16'hA5C3, 16, 1'b1, 3);
    chk("t2_cyc", cyc, 22);
    chk("t2_dout", dout, 16'hA5C3);
    chk("t2_valid", dout_valid, 1);
    tick();
    dout_ready = 1'b0;
    d0 = dlv_cnt;
    send(16'h1234, 16, 1'b1, 0);
    chk("t3_dout1", dout, 16'h1234);
    chk("t3_ovf0", overflow, 0);
    send(16'hFFFF, 16, 1'b1, 0);
    chk("t3_dout_held", dout, 16'h1234);
    chk("t3_valid_held", dout_valid, 1);
    chk("t3_ovf1", overflow, 1);
    dout_ready = 1'b1;
    tick();
    chk("t3_drained", dout_valid, 0);
    chk("t3_dlv_cnt", dlv_cnt - d0, 1);
    chk("t3_dlv_word", last_dout, 16'h1234);
    chk("t3_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_ovf_clr", overflow, 0);
    fe0 = fe_cnt;
    d0 = dlv_cnt;
    send(16'hFFFF, 9, 1'b1, 0);
    chk("t4_fe_before", frame_err, 0);
    send(16'h00FF, 16, 1'b1, 0);
    chk("t4_dout", dout, 16'h00FF);
    repeat (2) tick();
    chk("t4_fe_pulses", fe_cnt - fe0, 1);
    chk("t4_dlv_cnt", dlv_cnt - d0, 1);
    chk("t4_dlv_word", last_dout, 16'h00FF);
    dout_ready = 1'b0;
    send(16'h5555, 16, 1'b1, 0);
    send(16'hFFFF, 7, 1'b1, 0);
    send(16'hFFFF, 16, 1'b1, 0);
    chk("t5_pre_ovf", overflow, 1);
    send(16'hFFFF, 7, 1'b1, 0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    dout_ready = 1'b1;
    chk("t5_dout", dout, 0);
    chk("t5_valid", dout_valid, 0);
    chk("t5_fe", frame_err, 0);
    chk("t5_ovf", overflow, 0);
    send(16'hBEEF, 16, 1'b1, 0);
    chk("t5_beef", dout, 16'hBEEF);
    chk("t5_beef_valid", dout_valid, 1);
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    d0 = dlv_cnt;
    a0 = dlv_a;
    send(16'h0001, 16, 1'b1, 0);
    chk("t6_w0", dout_a, 16'h0001);
    chk("t6_w0_valid", dout_valid_a, 1);
    send(16'h8000, 16, 1'b0, 0);
    chk("t6_cyc", cyc, 16);
    chk("t6_w1", dout_a, 16'h8000);
    chk("t6_w1_valid", dout_valid_a, 1);
    chk("t6_norearm_valid", dout_valid, 0);
    tick();
    chk("t6_dlv_a", dlv_a - a0, 2);
    chk("t6_last_a", last_a, 16'h8000);
    chk("t6_norearm_dlv", dlv_cnt - d0, 1);
    chk("t6_norearm_word", last_dout, 16'h0001);
    chk("t6_fe_a", frame_err_a, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
